spimregbank: RTL

Register-bank responder on the SPI master's internal `avbreg_*` bus. It answers the word-wide, waitrequest-gated write and read requests issued by the AVMM bridge. It holds the master command register (`m_cmd`), the transmit word buffer (`wrt_buf`) and the receive word buffer (`rd_buf`). It presents command, configuration and buffer ports to the SPI shift engine.

---
 rtl/spimregbank.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/spimregbank.sv
// rtl/spimregbank.sv - register bank responder on the SPI master avbreg bus
//
// Holds m_cmd, the transmit word buffer (wrt_buf) and the receive word
// buffer (rd_buf), and answers waitrequest-gated bus writes and reads.
// Optional build macro: SPIMREG_BUSY_STALL_EN
//
// Ports:
//   m_avmm_clk, m_avmm_rst_n    clock, asynchronous active-low reset
//   avbreg_write/read/addr      bus request (held until accepted)
//   avbbyte_en, avbreg_wdata    write byte enables and data
//   avbreg_waitreq              low for one cycle to accept a request
//   avbreg_rdatavld/rdata       read-data-valid pulse and read data
//   spi_busy                    engine transfer in progress
//   cmd_go, cmd_cfg             start pulse and m_cmd[30:1] to the engine
//   wbuf_raddr/wbuf_rdata       engine combinational read port of wrt_buf
//   rbuf_we/waddr/wdata         engine write port of rd_buf
module spimregbank #(
  parameter logic [15:0] WBUF_BASE = 16'h0200,
  parameter logic [15:0] RBUF_BASE = 16'h0400,
  parameter int unsigned BUF_AW    = 7
) (
  input  logic              m_avmm_clk,
  input  logic              m_avmm_rst_n,
  input  logic              avbreg_write,
  input  logic              avbreg_read,
  input  logic [15:0]       avbreg_addr,
  input  logic [3:0]        avbbyte_en,
  input  logic [31:0]       avbreg_wdata,
  output logic              avbreg_waitreq,
  output logic              avbreg_rdatavld,
  output logic [31:0]       avbreg_rdata,
  input  logic              spi_busy,
  output logic              cmd_go,
  output logic [29:0]       cmd_cfg,
  input  logic [BUF_AW-1:0] wbuf_raddr,
  output logic [31:0]       wbuf_rdata,
  input  logic              rbuf_we,
  input  logic [BUF_AW-1:0] rbuf_waddr,
  input  logic [31:0]       rbuf_wdata
);

  localparam int unsigned DEPTH = 1 << BUF_AW;
  localparam int unsigned WB    = BUF_AW + 2;  // low address bits inside one window

  typedef enum logic [1:0] {IDLE, WACK, RACK, RVLD} state_t;

  state_t              state_q, state_d;
  logic [29:0]         cfg_q;
  logic [31:0]         rdata_q;
  logic                waitreq_q;
  logic                rdatavld_q;
  logic                cmd_go_q;
  logic                wr_cmd_q, wr_wbuf_q;
  logic [BUF_AW-1:0]   wr_idx_q;
  logic [31:0]         wr_data_q;
  logic [3:0]          wr_be_q;

  logic [31:0]         wbuf_mem [DEPTH];
  logic [31:0]         rbuf_mem [DEPTH];

  logic                hit_cmd, hit_wbuf, hit_rbuf;
  logic [BUF_AW-1:0]   idx;
  logic                stall;
  logic [31:0]         rd_mux;
  logic [31:0]         cmd_merged;
  logic                go_req;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^avbreg_addr[1:0];

  assign hit_cmd  = (avbreg_addr[15:2] == 14'd0);
  assign hit_wbuf = (avbreg_addr[15:WB] == WBUF_BASE[15:WB]);
  assign hit_rbuf = (avbreg_addr[15:WB] == RBUF_BASE[15:WB]);
  assign idx      = avbreg_addr[WB-1:2];

  // Stall decision is made for the access that would actually be taken:
  // a pending write shadows a simultaneous read.
  always_comb begin
    stall = 1'b0;
`ifdef SPIMREG_BUSY_STALL_EN
    if (avbreg_write) begin
      stall = spi_busy && (hit_wbuf || hit_cmd);
    end else if (avbreg_read) begin
      stall = spi_busy && (hit_wbuf || hit_rbuf);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (avbreg_write && !stall) begin
          state_d = WACK;
        end else if (avbreg_read && !avbreg_write && !stall) begin
          state_d = RACK;
        end
      end
      WACK:    state_d = IDLE;
      RACK:    state_d = RVLD;
      RVLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 32'h0;
    if (hit_cmd) begin
      rd_mux = {spi_busy, cfg_q, 1'b0};
    end else if (hit_wbuf) begin
      rd_mux = wbuf_mem[idx];
    end else if (hit_rbuf) begin
      rd_mux = rbuf_mem[idx];
    end
  end

  // Byte-merge the latched write into the current m_cmd image; bit0 and
  // bit31 are not storage, only cfg bits are kept from the result.
  always_comb begin
    cmd_merged = {1'b0, cfg_q, 1'b0};
    for (int b = 0; b < 4; b++) begin
      if (wr_be_q[b]) begin
        cmd_merged[8*b +: 8] = wr_data_q[8*b +: 8];
      end
    end
  end

  always_comb begin
    go_req = wr_be_q[0] && wr_data_q[0];
`ifndef SPIMREG_BUSY_STALL_EN
    // Without stalling, a go that lands while the engine is busy is dropped.
    if (spi_busy) begin
      go_req = 1'b0;
    end
`endif
  end

  always_ff @(posedge m_avmm_clk or negedge m_avmm_rst_n) begin
    if (!m_avmm_rst_n) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      rdata_q    <= '0;
      waitreq_q  <= 1'b1;
      rdatavld_q <= 1'b0;
      cmd_go_q   <= 1'b0;
      wr_cmd_q   <= 1'b0;
      wr_wbuf_q  <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      wr_be_q    <= '0;
    end else begin
      state_q    <= state_d;
      waitreq_q  <= !((state_d == WACK) || (state_d == RACK));
      rdatavld_q <= (state_d == RVLD);
      cmd_go_q   <= (state_q == WACK) && wr_cmd_q && go_req;
      if (state_q == IDLE && state_d == WACK) begin
        wr_cmd_q  <= hit_cmd;
        wr_wbuf_q <= hit_wbuf;
        wr_idx_q  <= idx;
        wr_data_q <= avbreg_wdata;
        wr_be_q   <= avbbyte_en;
      end
      if (state_q == IDLE && state_d == RACK) begin
        rdata_q <= rd_mux;
      end
      if (state_q == WACK && wr_cmd_q) begin
        cfg_q <= cmd_merged[30:1];
      end
    end
  end

  // Buffer storage has no reset; a reset mid-WACK leaves state_q in IDLE so
  // the pending write never reaches the array.
  always_ff @(posedge m_avmm_clk) begin
    if (state_q == WACK && wr_wbuf_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_q[b]) begin
          wbuf_mem[wr_idx_q][8*b +: 8] <= wr_data_q[8*b +: 8];
        end
      end
    end
    if (rbuf_we) begin
      rbuf_mem[rbuf_waddr] <= rbuf_wdata;
    end
  end

  assign avbreg_waitreq  = waitreq_q;
  assign avbreg_rdatavld = rdatavld_q;
  assign avbreg_rdata    = rdata_q;
  assign cmd_go          = cmd_go_q;
  assign cmd_cfg         = cfg_q;
  assign wbuf_rdata      = wbuf_mem[wbuf_raddr];

endmodule
